mem_arbiter: RTL and testbench

- Sequences and shares the single byte-wide RAM/IO port between two requesters: instruction fetch (32-bit reads) and the LSU (1/2/4-byte reads and writes).
- Sits between the ifetch unit and LSU on one side and the top-level RAM/IO bus on the other.
- Splits each access into per-byte RAM cycles and reassembles little-endian words.
- Handles IO write back-pressure and ROB rollback aborts.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for mem_arbiter: size codes, rw encoding, IO-region bits,
// FSM state encoding and small byte-lane helpers.
package mem_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int IO_SEL_HI_DEF = 17;
  localparam int IO_SEL_LO_DEF = 16;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_IF_RD = 2'd1;
  localparam logic [1:0] ST_LS_RD = 2'd2;
  localparam logic [1:0] ST_LS_WR = 2'd3;

  // Size code 11 is treated as a full word.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: nbytes = 3'd1;
      SZ_HALF: nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] idx);
    byte_lane = w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between ifetch (32-bit reads) and the LSU,
// splitting each access into byte cycles and reassembling little-endian data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int IO_SEL_HI = IO_SEL_HI_DEF,
  parameter int IO_SEL_LO = IO_SEL_LO_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_en_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,
  input  logic              lsu_en_in,
  input  logic              lsu_rw_in,
  input  logic [1:0]        lsu_size_in,
  input  logic [ADDR_W-1:0] lsu_addr_in,
  input  logic [31:0]       lsu_data_in,
  output logic              lsu_done_out,
  output logic [31:0]       lsu_data_out,
  output logic              busy_out,
  input  logic              rollback_in,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_n;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;
  logic              r_if_done;
  logic              r_lsu_done;
  logic [31:0]       r_if_data;
  logic [31:0]       r_lsu_data;

  logic              w_req_io;
  logic              w_cur_io;
  logic [2:0]        w_nxt;
  logic [1:0]        w_cap;
  logic [31:0]       w_rd_word;

  assign w_req_io  = &lsu_addr_in[IO_SEL_HI:IO_SEL_LO];
  assign w_cur_io  = &r_addr[IO_SEL_HI:IO_SEL_LO];
  assign w_nxt     = r_cnt + 3'd1;
  // Reads: r_cnt counts edges since acceptance; byte (r_cnt-1) arrives now.
  assign w_cap     = 2'(r_cnt - 3'd1);
  assign w_rd_word = r_buf | ({24'd0, mem_din} << {w_cap, 3'b000});

  assign busy_out     = (r_state != ST_IDLE);
  assign mem_a        = r_mem_a;
  assign mem_dout     = r_mem_dout;
  assign mem_wr       = r_mem_wr & rdy_in;
  assign if_done_out  = r_if_done;
  assign if_data_out  = r_if_data;
  assign lsu_done_out = r_lsu_done;
  assign lsu_data_out = r_lsu_data;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_n        <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_mem_wr   <= FALSE;
      r_if_done  <= FALSE;
      r_lsu_done <= FALSE;
      r_if_data  <= '0;
      r_lsu_data <= '0;
    end else if (rdy_in) begin
      r_if_done  <= FALSE;
      r_lsu_done <= FALSE;
      case (r_state)
        ST_IDLE: begin
          if (!rollback_in && lsu_en_in) begin
            r_addr  <= lsu_addr_in;
            r_n     <= nbytes(lsu_size_in);
            r_wdata <= lsu_data_in;
            r_buf   <= '0;
            r_mem_a <= lsu_addr_in;
            if (lsu_rw_in == RW_READ) begin
              r_state  <= ST_LS_RD;
              r_cnt    <= '0;
              r_mem_wr <= FALSE;
            end else begin
              r_state <= ST_LS_WR;
              if (w_req_io && io_buffer_full) begin
                r_cnt    <= '0;
                r_mem_wr <= FALSE;
              end else begin
                r_cnt      <= 3'd1;
                r_mem_wr   <= TRUE;
                r_mem_dout <= lsu_data_in[7:0];
              end
            end
          end else if (!rollback_in && if_en_in) begin
            r_state  <= ST_IF_RD;
            r_addr   <= if_addr_in;
            r_n      <= 3'd4;
            r_buf    <= '0;
            r_mem_a  <= if_addr_in;
            r_cnt    <= '0;
            r_mem_wr <= FALSE;
          end
        end
        ST_IF_RD, ST_LS_RD: begin
          if (rollback_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            if (w_nxt < r_n) r_mem_a <= r_addr + ADDR_W'(w_nxt);
            if (r_cnt != 3'd0 && r_cnt == r_n) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              if (r_state == ST_IF_RD) begin
                r_if_done <= TRUE;
                r_if_data <= w_rd_word;
              end else begin
                r_lsu_done <= TRUE;
                r_lsu_data <= w_rd_word;
              end
            end else begin
              if (r_cnt != 3'd0) r_buf <= w_rd_word;
              r_cnt <= w_nxt;
            end
          end
        end
        ST_LS_WR: begin
          // Stores are already committed, so rollback is ignored here.
          if (r_cnt == r_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_mem_wr   <= FALSE;
            r_lsu_done <= TRUE;
          end else if (w_cur_io && io_buffer_full) begin
            r_mem_wr <= FALSE;
          end else begin
            r_mem_a    <= r_addr + ADDR_W'(r_cnt);
            r_mem_dout <= byte_lane(r_wdata, r_cnt[1:0]);
            r_mem_wr   <= TRUE;
            r_cnt      <= w_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_en_in, lsu_en_in, lsu_rw_in, rollback_in, io_buffer_full;
  logic [31:0] if_addr_in, lsu_addr_in, lsu_data_in;
  logic [1:0]  lsu_size_in;
  logic        if_done_out, lsu_done_out, busy_out, mem_wr;
  logic [31:0] if_data_out, lsu_data_out, mem_a;
  logic [7:0]  mem_din, mem_dout;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_en_in(if_en_in), .if_addr_in(if_addr_in), .if_done_out(if_done_out),
    .if_data_out(if_data_out), .lsu_en_in(lsu_en_in), .lsu_rw_in(lsu_rw_in),
    .lsu_size_in(lsu_size_in), .lsu_addr_in(lsu_addr_in), .lsu_data_in(lsu_data_in),
    .lsu_done_out(lsu_done_out), .lsu_data_out(lsu_data_out), .busy_out(busy_out),
    .rollback_in(rollback_in), .io_buffer_full(io_buffer_full), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0]  ram [65536];
  logic [39:0] wq [$];

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      wq.push_back({mem_a, mem_dout});
    end
  end

  int total = 0;
  int bad   = 0;
  int lat;
  logic [31:0] a_log [16];
  logic        wr_log [16];
  logic        busy_log [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Waits for the selected done pulse, logging the bus each cycle; lat = -1 on timeout.
  task automatic run(input bit is_if, input int rb_at, input int io_at, input int bound,
                     output int l);
    l = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk_in);
      if (i <= 16) begin
        a_log[i-1] = mem_a; wr_log[i-1] = mem_wr; busy_log[i-1] = busy_out;
      end
      if (i == rb_at) begin rollback_in = 1'b1; if_en_in = 1'b0; end
      if (i == rb_at + 1) rollback_in = 1'b0;
      if (i == io_at) io_buffer_full = 1'b0;
      if (is_if ? if_done_out : lsu_done_out) begin l = i - 1; break; end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    ram[16'h1004] = 8'h93; ram[16'h1005] = 8'h00; ram[16'h1006] = 8'h10; ram[16'h1007] = 8'h00;
    rst_in = 0; rdy_in = 1; if_en_in = 0; lsu_en_in = 0; lsu_rw_in = 1; rollback_in = 0;
    io_buffer_full = 0; if_addr_in = 0; lsu_addr_in = 0; lsu_data_in = 0; lsu_size_in = 0;
    repeat (2) @(negedge clk_in);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_if_done", 32'(if_done_out), 0);
    rst_in = 1;
    @(negedge clk_in);

    // Fetch 0x1000
    if_addr_in = 32'h1000; if_en_in = 1;
    run(1, 0, 0, 12, lat);
    if_en_in = 0;
    chk("if_lat", 32'(lat), 5);
    chk("if_data", if_data_out, 32'h0000_0513);
    for (int k = 0; k < 4; k++) begin
      chk("if_addr_seq", a_log[k], 32'h1000 + 32'(k));
      chk("if_wr_low", 32'(wr_log[k]), 0);
    end
    chk("if_busy_done_cyc", 32'(busy_log[5]), 0);
    @(negedge clk_in);
    chk("if_pulse_1cyc", 32'(if_done_out), 0);

    // SW 0xDEADBEEF to 0x40
    wq.delete();
    lsu_rw_in = 0; lsu_size_in = 2'b10; lsu_addr_in = 32'h40; lsu_data_in = 32'hDEADBEEF;
    lsu_en_in = 1;
    run(0, 0, 0, 12, lat);
    lsu_en_in = 0;
    chk("sw_lat", 32'(lat), 4);
    chk("sw_nwr", 32'(wq.size()), 4);
    for (int k = 0; k < 4; k++) chk("sw_wr_cyc", 32'(wr_log[k]), 1);
    chk("sw_wr_off", 32'(wr_log[4]), 0);
    if (wq.size() == 4) begin
      chk("sw_b0", {24'd0, wq[0][7:0]}, 32'hEF); chk("sw_a0", wq[0][39:8], 32'h40);
      chk("sw_b1", {24'd0, wq[1][7:0]}, 32'hBE); chk("sw_a1", wq[1][39:8], 32'h41);
      chk("sw_b2", {24'd0, wq[2][7:0]}, 32'hAD); chk("sw_a2", wq[2][39:8], 32'h42);
      chk("sw_b3", {24'd0, wq[3][7:0]}, 32'hDE); chk("sw_a3", wq[3][39:8], 32'h43);
    end
    @(negedge clk_in);
    chk("sw_pulse_1cyc", 32'(lsu_done_out), 0);

    // LB 0x1001 and fetch 0x1004 raised together
    lsu_rw_in = 1; lsu_size_in = 2'b00; lsu_addr_in = 32'h1001; lsu_en_in = 1;
    if_addr_in = 32'h1004; if_en_in = 1;
    run(0, 0, 0, 12, lat);
    lsu_en_in = 0;
    chk("lb_lat", 32'(lat), 2);
    chk("lb_data", lsu_data_out, 32'h05);
    chk("lb_if_waits", 32'(if_done_out), 0);
    run(1, 0, 0, 12, lat);
    if_en_in = 0;
    chk("pri_if_lat", 32'(lat), 5);
    chk("pri_if_data", if_data_out, 32'h0010_0093);

    // LH 0x1000, upper half zero
    lsu_rw_in = 1; lsu_size_in = 2'b01; lsu_addr_in = 32'h1000; lsu_en_in = 1;
    run(0, 0, 0, 12, lat);
    lsu_en_in = 0;
    chk("lh_lat", 32'(lat), 3);
    chk("lh_data", lsu_data_out, 32'h0000_0513);

    // SB to IO region with write buffer full for three edges
    wq.delete();
    io_buffer_full = 1;
    lsu_rw_in = 0; lsu_size_in = 2'b00; lsu_addr_in = 32'h0003_0000; lsu_data_in = 32'h41;
    lsu_en_in = 1;
    run(0, 0, 3, 12, lat);
    lsu_en_in = 0;
    chk("io_lat", 32'(lat), 4);
    for (int k = 0; k < 3; k++) chk("io_stall_wr", 32'(wr_log[k]), 0);
    chk("io_issue_wr", 32'(wr_log[3]), 1);
    chk("io_issue_a", a_log[3], 32'h0003_0000);
    chk("io_nwr", 32'(wq.size()), 1);
    if (wq.size() == 1) chk("io_byte", {24'd0, wq[0][7:0]}, 32'h41);

    // Rollback during fetch byte 2
    if_addr_in = 32'h1000; if_en_in = 1;
    run(1, 3, 0, 10, lat);
    if_en_in = 0;
    chk("rb_if_nodone", 32'(lat), 32'hFFFF_FFFF);
    chk("rb_if_idle", 32'(busy_log[3]), 0);
    chk("rb_if_data_kept", if_data_out, 32'h0010_0093);

    // Rollback during SH: store still completes
    wq.delete();
    lsu_rw_in = 0; lsu_size_in = 2'b01; lsu_addr_in = 32'h80; lsu_data_in = 32'h0000_CAFE;
    lsu_en_in = 1;
    run(0, 1, 0, 12, lat);
    lsu_en_in = 0;
    chk("rb_sh_lat", 32'(lat), 2);
    chk("rb_sh_nwr", 32'(wq.size()), 2);
    if (wq.size() == 2) begin
      chk("rb_sh_b0", {24'd0, wq[0][7:0]}, 32'hFE);
      chk("rb_sh_b1", {24'd0, wq[1][7:0]}, 32'hCA);
    end

    // Freeze mid-SB: mem_wr gated, nothing advances
    wq.delete();
    lsu_rw_in = 0; lsu_size_in = 2'b00; lsu_addr_in = 32'h200; lsu_data_in = 32'h55;
    lsu_en_in = 1;
    @(negedge clk_in);
    chk("frz_wr_before", 32'(mem_wr), 1);
    rdy_in = 0;
    #1 chk("frz_wr_gated", 32'(mem_wr), 0);
    repeat (2) @(negedge clk_in);
    chk("frz_busy", 32'(busy_out), 1);
    chk("frz_nodone", 32'(lsu_done_out), 0);
    chk("frz_mem_a", mem_a, 32'h200);
    rdy_in = 1;
    @(negedge clk_in);
    chk("frz_done", 32'(lsu_done_out), 1);
    lsu_en_in = 0;
    chk("frz_nwr", 32'(wq.size()), 1);

    // Reset pulse mid-LW
    lsu_rw_in = 1; lsu_size_in = 2'b10; lsu_addr_in = 32'h1004; lsu_en_in = 1;
    repeat (2) @(negedge clk_in);
    rst_in = 0;
    #1;
    chk("rst_lw_busy", 32'(busy_out), 0);
    chk("rst_lw_mem_a", mem_a, 0);
    chk("rst_lw_dout", 32'(mem_dout), 0);
    chk("rst_lw_lsu_data", lsu_data_out, 0);
    chk("rst_lw_if_data", if_data_out, 0);
    lsu_en_in = 0;
    @(negedge clk_in);
    rst_in = 1;
    lat = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (lsu_done_out) lat++;
    end
    chk("rst_lw_nodone", 32'(lat), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
